spi_reg_slave: RTL

Parametrised successor to the icoboard single-byte SPI echo slave. It receives framed SPI transactions from the Raspberry Pi, oversampled in the `ico_clk` domain, and decodes a command word (read/write + address) followed by a data word. A bank of `2**ADDR_BITS` registers of `WIDTH` bits is written from MOSI or read back on MISO. The flattened register bank drives board GPIO/PMOD outputs.

---
 rtl/spi_reg_slave_pkg.sv | 19 +
 rtl/spi_reg_slave_sync_edge.sv | 32 +++
 rtl/spi_reg_slave.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_slave_pkg.sv
// Shared definitions for the SPI register slave: FSM states and opcode encoding.
package spi_reg_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  // Opcode lives in the MSB of the command word.
  function automatic int op_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/spi_reg_slave_sync_edge.sv
// N-stage synchroniser with rising/falling edge detection on the last two samples.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the asynchronous input through the chain and keep the previous sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{INIT}};
      r_prev <= INIT;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_slave.sv
// Oversampled SPI slave: command word (R/W + address) then data word into a register bank.
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter int   ADDR_BITS   = 2,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                             ico_clk,
  input  logic                             rst,
  input  logic                             pi_clk,
  input  logic                             SEL,
  input  logic                             MOSI,
  output logic                             MISO,
  output logic [WIDTH*(2**ADDR_BITS)-1:0]  regs_out,
  output logic                             wr_strobe,
  output logic [ADDR_BITS-1:0]             wr_addr,
  output logic                             frame_err
);

  localparam int NREG = 2**ADDR_BITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int OPB  = op_bit(WIDTH);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_sel_q, w_sel_rise, w_sel_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  // SCLK starts at its idle level so no edge appears out of reset.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(CPOL)) u_sclk (
    .i_clk(ico_clk), .i_rst(rst), .i_d(pi_clk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  // SEL starts "active" so a frame already in flight at reset is never armed.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sel (
    .i_clk(ico_clk), .i_rst(rst), .i_d(SEL),
    .o_q(w_sel_q), .o_rise(w_sel_rise), .o_fall(w_sel_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .i_clk(ico_clk), .i_rst(rst), .i_d(MOSI),
    .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  state_t              r_state, w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_rx_sr, r_tx_sr, w_rx_next;
  logic [WIDTH-1:0]    r_regs [NREG];
  logic                r_op, r_armed, r_wr_strobe, r_frame_err;
  logic [ADDR_BITS-1:0] r_addr, r_wr_addr, w_cmd_addr;
  logic w_sel_active, w_lead, w_trail, w_cap, w_launch;
  logic w_do_cap, w_do_launch, w_cmd_done, w_data_done, w_err;

  assign w_unused     = ^{w_sclk_q, w_sel_rise, w_sel_fall, w_mosi_rise, w_mosi_fall, r_rx_sr[WIDTH-1]};
  assign w_sel_active = ~w_sel_q;
  assign w_lead       = CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail      = CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_cap        = CPHA ? w_trail : w_lead;
  assign w_launch     = CPHA ? w_lead : w_trail;
  assign w_rx_next    = {r_rx_sr[WIDTH-2:0], w_mosi_q};
  assign w_cmd_addr   = w_rx_next[ADDR_BITS-1:0];

  // FSM state register.
  always_ff @(posedge ico_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state plus capture/launch/commit/abort decisions; SEL deassert wins over edges.
  always_comb begin
    w_state_next = r_state;
    w_do_cap     = 1'b0;
    w_do_launch  = 1'b0;
    w_cmd_done   = 1'b0;
    w_data_done  = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_active && r_armed) w_state_next = ST_CMD;
        else                         w_state_next = ST_IDLE;
      end
      ST_CMD: begin
        if (!w_sel_active) begin
          w_state_next = ST_IDLE;
          w_err        = (r_cnt != CW'(0));
        end else if (w_cap) begin
          w_do_cap = 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_state_next = ST_DATA;
            w_cmd_done   = 1'b1;
          end else begin
            w_state_next = ST_CMD;
          end
        end else begin
          w_state_next = ST_CMD;
        end
      end
      ST_DATA: begin
        if (!w_sel_active) begin
          w_state_next = ST_IDLE;
          w_err        = 1'b1;
        end else if (w_cap) begin
          w_do_cap = 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_state_next = ST_DONE;
            w_data_done  = 1'b1;
          end else begin
            w_state_next = ST_DATA;
          end
        end else begin
          w_state_next = ST_DATA;
          w_do_launch  = w_launch && (r_cnt != CW'(0));
        end
      end
      ST_DONE: begin
        if (!w_sel_active) w_state_next = ST_IDLE;
        else               w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Shift registers, bit counter, register bank and pulsed outputs.
  always_ff @(posedge ico_clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_op        <= 1'b0;
      r_addr      <= '0;
      r_armed     <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      r_armed     <= r_armed | w_sel_q;
      r_wr_strobe <= 1'b0;
      r_frame_err <= w_err;
      if (!w_sel_active || r_state == ST_IDLE) begin
        r_cnt   <= '0;
        r_rx_sr <= '0;
        r_tx_sr <= '0;
      end else if (w_do_cap) begin
        r_rx_sr <= w_rx_next;
        r_cnt   <= (w_cmd_done || w_data_done) ? CW'(0) : r_cnt + CW'(1);
        if (w_cmd_done) begin
          r_op    <= w_rx_next[OPB];
          r_addr  <= w_cmd_addr;
          r_tx_sr <= (w_rx_next[OPB] == OP_READ) ? r_regs[w_cmd_addr] : '0;
        end else if (w_data_done) begin
          r_tx_sr <= '0;
          if (r_op == OP_WRITE) begin
            r_regs[r_addr] <= w_rx_next;
            r_wr_strobe    <= 1'b1;
            r_wr_addr      <= r_addr;
          end else begin
            r_wr_strobe <= 1'b0;
          end
        end else begin
          r_tx_sr <= r_tx_sr;
        end
      end else if (w_do_launch) begin
        r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
      end else begin
        r_tx_sr <= r_tx_sr;
      end
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign regs_out[k*WIDTH +: WIDTH] = r_regs[k];
  end

  assign MISO      = r_tx_sr[WIDTH-1];
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule
